// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: multi-product vending controller.
// Coins add credit up to a ceiling. A product select either starts a dispense
// or pulses deny. Cancel or an inactivity timeout refunds the credit through
// the change handshake.
//
// Handshake rule for both channels (disp_*, change_*): the controller raises
// valid with the payload already stable and holds both until the edge that
// samples ack=1, so a transfer completes on that edge. An ack seen while
// valid is low is ignored. valid is high for at least one cycle, even when ack
// is already high as the controller enters VEND or CHANGE.
module vend_ctrl_param #(
   parameter int NUM_PROD   = 4,
   parameter int CREDIT_W   = 4,
   parameter int COIN_VAL   = 1,
   parameter int MAX_CREDIT = 10,
   parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {4'd5, 4'd4, 4'd3, 4'd2},
   parameter int TIMEOUT    = 1024,
   localparam int ID_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1,
   localparam int TMR_W     = $clog2(TIMEOUT)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin,
   input  logic [NUM_PROD-1:0] sel,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic                disp_valid,
   output logic [ID_W-1:0]     disp_id,
   input  logic                disp_ack,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   input  logic                change_ack,
   output logic                coin_reject,
   output logic                deny,
   output logic [1:0]          dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_VEND   = 2'd1,
      S_CHANGE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                disp_valid_q, disp_valid_d;
   logic [ID_W-1:0]     disp_id_q, disp_id_d;
   logic                change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
   logic                coin_reject_q, coin_reject_d;
   logic                deny_q, deny_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;

   // Previous samples reset high: an input held high through reset is not an event.
   logic                coin_prev_q;
   logic [NUM_PROD-1:0] sel_prev_q;
   logic                cancel_prev_q;

   logic                coin_edge;
   logic [NUM_PROD-1:0] sel_edge;
   logic                cancel_edge;
   logic                sel_hit;
   logic [ID_W-1:0]     sel_idx;
   logic [CREDIT_W-1:0] sel_price;
   logic [CREDIT_W:0]   coin_sum;
   logic                serviced;

   assign coin_edge   = coin & ~coin_prev_q;
   assign sel_edge    = sel & ~sel_prev_q;
   assign cancel_edge = cancel & ~cancel_prev_q;

   // One bit wider than credit so the ceiling check cannot wrap.
   assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(COIN_VAL);

   // Samples the inputs once per cycle for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!reset) begin
         coin_prev_q   <= 1'b1;
         sel_prev_q    <= '1;
         cancel_prev_q <= 1'b1;
      end else begin
         coin_prev_q   <= coin;
         sel_prev_q    <= sel;
         cancel_prev_q <= cancel;
      end
   end

   // Picks the lowest-index rising select and looks up its price.
   always_comb begin
      sel_hit   = 1'b0;
      sel_idx   = '0;
      sel_price = '0;
      for (int i = NUM_PROD - 1; i >= 0; i--) begin
         if (sel_edge[i]) begin
            sel_hit   = 1'b1;
            sel_idx   = ID_W'(i);
            sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
         end
      end
   end

   // State, credit, timer and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         disp_valid_q   <= 1'b0;
         disp_id_q      <= '0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         coin_reject_q  <= 1'b0;
         deny_q         <= 1'b0;
         tmr_q          <= '0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         disp_valid_q   <= disp_valid_d;
         disp_id_q      <= disp_id_d;
         change_valid_q <= change_valid_d;
         change_amt_q   <= change_amt_d;
         coin_reject_q  <= coin_reject_d;
         deny_q         <= deny_d;
         tmr_q          <= tmr_d;
      end
   end

   // Next state and outputs. In IDLE the priority is cancel, then select, then coin.
   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      disp_valid_d   = disp_valid_q;
      disp_id_d      = disp_id_q;
      change_valid_d = change_valid_q;
      change_amt_d   = change_amt_q;
      coin_reject_d  = 1'b0;
      deny_d         = 1'b0;
      tmr_d          = '0;
      serviced       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cancel_edge && (credit_q != '0)) begin
               state_d        = S_CHANGE;
               change_valid_d = 1'b1;
               change_amt_d   = credit_q;
               serviced       = 1'b1;
            end else if (sel_hit) begin
               if (credit_q >= sel_price) begin
                  state_d      = S_VEND;
                  disp_valid_d = 1'b1;
                  disp_id_d    = sel_idx;
                  credit_d     = credit_q - sel_price;
                  serviced     = 1'b1;
               end else begin
                  deny_d = 1'b1;
               end
            end

            // A coin that arrives with a serviced cancel or select is refused.
            if (coin_edge) begin
               if (serviced) begin
                  coin_reject_d = 1'b1;
               end else if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
               end else begin
                  coin_reject_d = 1'b1;
               end
            end

            // Inactivity timer: any event or zero credit restarts it.
            if (coin_edge || sel_hit || cancel_edge || (credit_q == '0)) begin
               tmr_d = '0;
            end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
               state_d        = S_CHANGE;
               change_valid_d = 1'b1;
               change_amt_d   = credit_q;
               tmr_d          = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         S_VEND: begin
            coin_reject_d = coin_edge;
            if (disp_ack) begin
               disp_valid_d = 1'b0;
               if (credit_q != '0) begin
                  state_d        = S_CHANGE;
                  change_valid_d = 1'b1;
                  change_amt_d   = credit_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_CHANGE: begin
            coin_reject_d = coin_edge;
            if (change_ack) begin
               change_valid_d = 1'b0;
               credit_d       = '0;
               state_d        = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign credit       = credit_q;
   assign disp_valid   = disp_valid_q;
   assign disp_id      = disp_id_q;
   assign change_valid = change_valid_q;
   assign change_amt   = change_amt_q;
   assign coin_reject  = coin_reject_q;
   assign deny         = deny_q;
   assign dbg_state_o  = state_q;

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending-machine controller: the next generation of the board's single-product Moore/Mealy vending FSMs. It supports NUM_PROD products with individual prices, configurable coin value and credit ceiling, a ready/valid handshake for both dispense and change return, cancel, and an inactivity timeout that refunds credit. It runs on the prescaled board clock downstream of the clock prescaler and drives LEDs/actuators through its handshake outputs.

## Interface

Parameters:
- NUM_PROD, 4, number of products (≥2)
- CREDIT_W, 4, credit/price width
- COIN_VAL, 1, credit units added per accepted coin
- MAX_CREDIT, 10, credit ceiling (< 2^CREDIT_W)
- PRICES, {4'd5,4'd4,4'd3,4'd2}, packed NUM_PROD×CREDIT_W; slice i = price of product i; each in 1..MAX_CREDIT
- TIMEOUT, 1024, idle cycles before automatic refund (≥2)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- coin  in  1  level; each rising edge = one coin
- sel  in  NUM_PROD  level; rising edge on bit i = select product i
- cancel  in  1  level; rising edge = refund request
- credit  out  CREDIT_W  current credit
- disp_valid  out  1  dispense request
- disp_id  out  max(1,$clog2(NUM_PROD))  product being dispensed
- disp_ack  in  1  dispense accepted
- change_valid  out  1  change request
- change_amt  out  CREDIT_W  change amount
- change_ack  in  1  change accepted
- coin_reject  out  1  one-cycle pulse: coin not credited
- deny  out  1  one-cycle pulse: select with insufficient credit

## Operation

- Edge detection: coin, sel, cancel registered once; edge = input high AND previous sample low. Previous-sample registers reset to 1, so an input held high through reset produces no event.
- Multiple sel bits rising together: lowest index wins; others ignored.
- States: IDLE, VEND, CHANGE.
- IDLE, priority cancel > sel > coin:
  - cancel edge, credit>0 → CHANGE, change_amt=credit. Credit=0 → ignored.
  - sel edge i, credit ≥ PRICES[i] → VEND, disp_id=i, credit ← credit−PRICES[i].
  - sel edge i, credit < PRICES[i] → deny pulse; stay IDLE; credit unchanged.
  - coin edge: credit+COIN_VAL (computed CREDIT_W+1 bits) ≤ MAX_CREDIT → credit += COIN_VAL; otherwise coin_reject pulse.
  - A coin edge in the same cycle as a serviced cancel or sel → coin_reject.
  - Timeout: counter clears on any coin/sel/cancel edge or when credit=0. Counts in IDLE while credit>0. Reaching TIMEOUT−1 → CHANGE with change_amt=credit.
- VEND: disp_valid=1, disp_id stable. On disp_ack sampled 1 → credit>0 ? CHANGE (change_amt=credit) : IDLE.
- CHANGE: change_valid=1, change_amt stable. On change_ack sampled 1 → credit ← 0, IDLE.
- Outside IDLE: coin edges → coin_reject. sel and cancel edges are ignored.
- Reset (reset=0 at a clock edge): state IDLE, credit=0, disp_valid=0, disp_id=0, change_valid=0, change_amt=0, coin_reject=0, deny=0, timeout count=0. This applies in any state; an in-flight handshake is abandoned.

## Timing

- All outputs are registered.
- Input sampled high at edge k (low at k−1) → credit/deny/coin_reject/disp_valid/change_valid update after edge k.
- coin_reject and deny are high for exactly one cycle.
- disp_valid rises after the sel edge and falls after the edge where disp_ack=1. If change is due, change_valid rises on that same edge.
- change_valid falls, and credit becomes 0, after the edge where change_ack=1.
- An ack sampled while the matching valid is 0 is ignored. An ack held high on VEND/CHANGE entry completes the handshake on the next edge (minimum 1 cycle valid).
- Timeout: with credit>0 and no events, change_valid rises exactly TIMEOUT cycles after the last event edge.

## Test plan

- Reset, then 3 coin pulses → credit 1,2,3; sel[1] edge → disp_valid=1, disp_id=1, credit=0. disp_ack → back to IDLE, no change_valid.
- 5 coins, sel[0] → credit 3. disp_ack → change_valid=1, change_amt=3. change_ack → credit=0, IDLE.
- 2 coins, sel[3] (price 5) → deny one cycle, credit stays 2. cancel → change_amt=2.
- 10 coins then an 11th → coin_reject pulse, credit stays 10. Coin during VEND → coin_reject, credit unchanged.
- sel[2] and sel[0] rise together with credit 4 → disp_id=0. Coin in the same cycle → coin_reject.
- TIMEOUT=16: 1 coin, then idle → change_valid rises 16 cycles after the coin edge, change_amt=1. reset=0 mid-VEND → all outputs 0 on the next edge.
